// File: rtl/hack_input_ctrl.sv
// hack_input_ctrl
// Input conditioner and memory-mapped input register file for the Hack PC.
// Button pins and the switch bank pass through two-stage synchronisers.
// Each button channel is debounced, and its press/release edges are latched
// into sticky write-1-to-clear registers. An optional per-channel auto-repeat
// machine raises extra press events while a button stays held.
// The read port is combinational from registers, so the CPU's inM path sees
// the selected register in the same cycle that it selects it.

module hack_input_ctrl #(
  parameter int N_CH         = 5,
  parameter int SW_W         = 16,
  parameter int DB_CYCLES    = 125000,
  parameter int REPEAT_EN    = 0,
  parameter int REPEAT_DELAY = 6250000,
  parameter int REPEAT_RATE  = 1250000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_raw,
  input  logic [SW_W-1:0] sw_raw,
  input  logic [1:0]      reg_sel,
  input  logic            wr_en,
  input  logic [15:0]     wr_data,
  output logic [15:0]     rd_data
);

  // Debounce counter only needs to reach DB_CYCLES-1 (DB_CYCLES >= 2).
  localparam int CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  // The repeat counter is shared by the DELAY and REPEAT phases, so it is
  // sized for the larger of the two terminal counts.
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W   = (RC_MAX > 1) ? $clog2(RC_MAX) : 1;
  localparam logic [RC_W-1:0] RC_DLY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] RC_RATE_LAST = RC_W'(REPEAT_RATE - 1);

  // Register-select encodings seen on the bridge.
  localparam logic [1:0] SEL_LEVEL   = 2'd0;
  localparam logic [1:0] SEL_PRESS   = 2'd1;
  localparam logic [1:0] SEL_RELEASE = 2'd2;
  localparam logic [1:0] SEL_SWITCH  = 2'd3;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Synchroniser stages.
  logic [N_CH-1:0] btn_s1_q;
  logic [N_CH-1:0] btn_s2_q;
  logic [SW_W-1:0] sw_s1_q;
  logic [SW_W-1:0] sw_s2_q;

  // Debounce state.
  logic [N_CH-1:0]  level_q;
  logic [N_CH-1:0]  level_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];

  // Level edges, valid on the edge where level_q takes level_d.
  logic [N_CH-1:0] rise_s;
  logic [N_CH-1:0] fall_s;

  // Auto-repeat state.
  rpt_state_e      rpt_q [N_CH];
  rpt_state_e      rpt_d [N_CH];
  logic [RC_W-1:0] rc_q  [N_CH];
  logic [RC_W-1:0] rc_d  [N_CH];
  logic [N_CH-1:0] rpt_set_s;

  // Sticky event registers.
  logic [N_CH-1:0] press_q;
  logic [N_CH-1:0] press_d;
  logic [N_CH-1:0] release_q;
  logic [N_CH-1:0] release_d;
  logic [N_CH-1:0] press_clr_s;
  logic [N_CH-1:0] release_clr_s;

  // Only the low N_CH bits of the write data reach a register.
  logic wr_data_unused_s;
  assign wr_data_unused_s = ^wr_data;

  // Two flip-flop synchronisers for buttons and switches.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1_q <= '0;
      btn_s2_q <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
    end else begin
      btn_s1_q <= btn_raw;
      btn_s2_q <= btn_s1_q;
      sw_s1_q  <= sw_raw;
      sw_s2_q  <= sw_s1_q;
    end
  end

  // Debounce: a new level is accepted only after DB_CYCLES consecutive
  // disagreeing samples; one agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (btn_s2_q[i] == level_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        level_d[i] = btn_s2_q[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Edge detection on the accepted level.
  always_comb begin
    rise_s = level_d & ~level_q;
    fall_s = ~level_d & level_q;
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      level_q <= level_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Auto-repeat next state: a long DELAY after the press, then a press event
  // every REPEAT_RATE cycles. A falling level always returns to IDLE. With
  // repeat disabled the machine is held in IDLE and never raises an event.
  always_comb begin
    rpt_set_s = '0;
    for (int i = 0; i < N_CH; i++) begin
      rpt_d[i] = rpt_q[i];
      rc_d[i]  = rc_q[i];
      if (REPEAT_EN == 0) begin
        rpt_d[i] = RPT_IDLE;
        rc_d[i]  = '0;
      end else if (fall_s[i]) begin
        rpt_d[i] = RPT_IDLE;
        rc_d[i]  = '0;
      end else begin
        case (rpt_q[i])
          RPT_IDLE: begin
            rc_d[i] = '0;
            if (rise_s[i]) begin
              rpt_d[i] = RPT_DELAY;
            end else begin
              rpt_d[i] = RPT_IDLE;
            end
          end
          RPT_DELAY: begin
            if (rc_q[i] == RC_DLY_LAST) begin
              rpt_set_s[i] = 1'b1;
              rpt_d[i]     = RPT_REPEAT;
              rc_d[i]      = '0;
            end else begin
              rc_d[i] = rc_q[i] + RC_W'(1);
            end
          end
          RPT_REPEAT: begin
            if (rc_q[i] == RC_RATE_LAST) begin
              rpt_set_s[i] = 1'b1;
              rc_d[i]      = '0;
            end else begin
              rc_d[i] = rc_q[i] + RC_W'(1);
            end
          end
          default: begin
            rpt_d[i] = RPT_IDLE;
            rc_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // Auto-repeat state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        rpt_q[i] <= RPT_IDLE;
        rc_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        rpt_q[i] <= rpt_d[i];
        rc_q[i]  <= rc_d[i];
      end
    end
  end

  // Write-1-to-clear masks decoded from the bridge strobe.
  always_comb begin
    press_clr_s   = '0;
    release_clr_s = '0;
    if (wr_en && (reg_sel == SEL_PRESS)) begin
      press_clr_s = wr_data[N_CH-1:0];
    end else if (wr_en && (reg_sel == SEL_RELEASE)) begin
      release_clr_s = wr_data[N_CH-1:0];
    end else begin
      press_clr_s   = '0;
      release_clr_s = '0;
    end
  end

  // Sticky event update: the set term is OR-ed in after the clear so a
  // coincident set wins over a clear of the same bit.
  always_comb begin
    press_d   = (press_q & ~press_clr_s) | rise_s | rpt_set_s;
    release_d = (release_q & ~release_clr_s) | fall_s;
  end

  // Sticky event registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_q   <= '0;
      release_q <= '0;
    end else begin
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Combinational read mux; unimplemented upper bits read as zero.
  always_comb begin
    rd_data = 16'h0000;
    case (reg_sel)
      SEL_LEVEL:   rd_data[N_CH-1:0] = level_q;
      SEL_PRESS:   rd_data[N_CH-1:0] = press_q;
      SEL_RELEASE: rd_data[N_CH-1:0] = release_q;
      SEL_SWITCH:  rd_data[SW_W-1:0] = sw_s2_q;
      default:     rd_data = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_hack_input_ctrl.sv
// Testbench for hack_input_ctrl: directed stimulus pushes per-cycle register
// expectations into a queue; a monitor pops them on the falling clock edge,
// sweeps reg_sel over the selected registers and compares rd_data.

module tb_hack_input_ctrl;

  localparam int N_CH = 5;
  localparam int SW_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  btn_raw;
  logic [15:0] sw_raw;
  logic [1:0]  reg_sel;
  logic [1:0]  stim_sel;
  logic [1:0]  mon_sel;
  logic        mon_active;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [15:0] rd_data;

  // Mask bits: 0 LEVEL, 1 PRESS, 2 RELEASE, 3 SWITCH.
  typedef struct packed {
    logic [3:0]  mask;
    logic [15:0] lvl;
    logic [15:0] prs;
    logic [15:0] rel;
    logic [15:0] sw;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks_total = 0;
  int    checks_pass  = 0;

  always #5 clk = ~clk;

  assign reg_sel = mon_active ? mon_sel : stim_sel;

  hack_input_ctrl #(
    .N_CH(N_CH), .SW_W(SW_W), .DB_CYCLES(4), .REPEAT_EN(1),
    .REPEAT_DELAY(10), .REPEAT_RATE(3)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .reg_sel(reg_sel), .wr_en(wr_en), .wr_data(wr_data), .rd_data(rd_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_regs(input logic [3:0] mask, input logic [15:0] lvl,
                             input logic [15:0] prs, input logic [15:0] rel,
                             input logic [15:0] sw, input string nm);
    exp_t e;
    e.mask = mask;
    e.lvl  = lvl;
    e.prs  = prs;
    e.rel  = rel;
    e.sw   = sw;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares one queued expectation per cycle in the low clock phase.
  initial begin : monitor
    exp_t        e;
    string       nm;
    logic [15:0] want;
    logic [1:0]  sel;
    mon_active = 1'b0;
    mon_sel    = 2'd0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        mon_active = 1'b1;
        for (int s = 0; s < 4; s++) begin
          if (e.mask[s]) begin
            sel = 2'(s);
            case (sel)
              2'd0:    want = e.lvl;
              2'd1:    want = e.prs;
              2'd2:    want = e.rel;
              default: want = e.sw;
            endcase
            mon_sel = sel;
            #1;
            checks_total++;
            if (rd_data === want) begin
              checks_pass++;
            end else begin
              $display("FAIL %s reg_sel=%0d: got %h, expected %h at %0t",
                       nm, sel, rd_data, want, $time);
            end
          end
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] exp_lvl;
    logic [15:0] exp_prs;
    reset    = 1'b1;
    btn_raw  = 5'b00000;
    sw_raw   = 16'h0000;
    stim_sel = 2'd0;
    wr_en    = 1'b0;
    wr_data  = 16'h0000;
    repeat (3) tick();
    expect_regs(4'hF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "reset_state");
    reset = 1'b0;
    tick();

    // Debounce accept on channel 2: level and press appear on edge 5.
    btn_raw = 5'b00100;
    for (int k = 1; k <= 6; k++) begin
      tick();
      expect_regs(4'b0011, (k == 6) ? 16'h0004 : 16'h0000,
                  (k == 6) ? 16'h0004 : 16'h0000, 16'h0000, 16'h0000, "db_accept");
    end
    stim_sel = 2'd1; wr_en = 1'b1; wr_data = 16'h0004;
    tick();
    wr_en = 1'b0; btn_raw = 5'b00000;
    expect_regs(4'b0011, 16'h0004, 16'h0000, 16'h0000, 16'h0000, "press_w1c");
    for (int j = 1; j <= 6; j++) begin
      tick();
      expect_regs(4'b0111, (j >= 6) ? 16'h0000 : 16'h0004, 16'h0000,
                  (j >= 6) ? 16'h0004 : 16'h0000, 16'h0000, "db_release");
    end
    stim_sel = 2'd2; wr_en = 1'b1; wr_data = 16'hFFFF;
    tick();
    wr_en = 1'b0;
    expect_regs(4'b0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "release_w1c");

    // Glitch reject: three-cycle pulse on channel 0.
    btn_raw = 5'b00001;
    for (int g = 0; g < 12; g++) begin
      if (g == 3) btn_raw = 5'b00000;
      tick();
      expect_regs(4'b0111, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "glitch_reject");
    end

    // Set wins: level rise on channel 1 coincides with a clear of PRESS[1].
    btn_raw = 5'b00010;
    for (int k = 1; k <= 5; k++) begin
      tick();
      expect_regs(4'b0011, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "setwin_pre");
    end
    stim_sel = 2'd1; wr_en = 1'b1; wr_data = 16'h0002;
    tick();
    wr_en = 1'b0; btn_raw = 5'b00000;
    expect_regs(4'b0011, 16'h0002, 16'h0002, 16'h0000, 16'h0000, "set_wins");
    repeat (6) tick();
    expect_regs(4'b0111, 16'h0000, 16'h0002, 16'h0002, 16'h0000, "setwin_release");
    stim_sel = 2'd1; wr_en = 1'b1; wr_data = 16'hFFFF;
    tick();
    stim_sel = 2'd2;
    tick();
    wr_en = 1'b0;
    expect_regs(4'b0110, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "clear_setwin");

    // Auto-repeat on channel 3 with PRESS[3] cleared every cycle.
    // Rise at edge 5, repeats at 15, 18, 21, 24; level falls at edge 25.
    btn_raw = 5'b01000; stim_sel = 2'd1; wr_en = 1'b1; wr_data = 16'h0008;
    for (int n = 0; n < 40; n++) begin
      if (n == 20) btn_raw = 5'b00000;
      tick();
      exp_lvl = (n >= 5 && n < 25) ? 16'h0008 : 16'h0000;
      exp_prs = (n == 5 || n == 15 || n == 18 || n == 21 || n == 24) ? 16'h0008 : 16'h0000;
      expect_regs(4'b0011, exp_lvl, exp_prs, 16'h0000, 16'h0000, "auto_repeat");
    end
    stim_sel = 2'd2; wr_data = 16'hFFFF;
    tick();
    wr_en = 1'b0;
    expect_regs(4'b0110, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "clear_repeat");

    // Switches and unused bits: all buttons pressed, switch bank 0xA5C3.
    sw_raw = 16'hA5C3; btn_raw = 5'b11111;
    for (int k = 1; k <= 6; k++) begin
      tick();
      expect_regs(4'b1011, (k == 6) ? 16'h001F : 16'h0000,
                  (k == 6) ? 16'h001F : 16'h0000, 16'h0000,
                  (k >= 2) ? 16'hA5C3 : 16'h0000, "switch_level");
    end
    stim_sel = 2'd0; wr_en = 1'b1; wr_data = 16'hFFFF;
    tick();
    stim_sel = 2'd3;
    tick();
    wr_en = 1'b0; btn_raw = 5'b00000;
    expect_regs(4'b1011, 16'h001F, 16'h001F, 16'h0000, 16'hA5C3, "ignored_writes");
    repeat (6) tick();
    expect_regs(4'b0111, 16'h0000, 16'h001F, 16'h001F, 16'h0000, "release_all");
    stim_sel = 2'd1; wr_en = 1'b1; wr_data = 16'hFFFF;
    tick();
    stim_sel = 2'd2;
    tick();
    wr_en = 1'b0;
    expect_regs(4'b0110, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "clear_all");

    // Reset mid-operation: PRESS[0] set and a release count at 2.
    btn_raw = 5'b00001;
    repeat (6) tick();
    expect_regs(4'b0011, 16'h0001, 16'h0001, 16'h0000, 16'h0000, "ch0_press");
    btn_raw = 5'b00000;
    repeat (4) tick();
    expect_regs(4'b0011, 16'h0001, 16'h0001, 16'h0000, 16'h0000, "pre_reset");
    btn_raw = 5'b00001; reset = 1'b1;
    tick();
    expect_regs(4'hF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, "reset_clears");
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      expect_regs(4'b1011, (k == 6) ? 16'h0001 : 16'h0000,
                  (k == 6) ? 16'h0001 : 16'h0000, 16'h0000,
                  (k >= 2) ? 16'hA5C3 : 16'h0000, "post_reset");
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 5 && exp_q.size() != 0; i++) begin
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    checks_total++;
    if (exp_q.size() == 0) begin
      checks_pass++;
    end else begin
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", checks_pass, checks_total);
    $finish;
  end

endmodule
